count_sequencer_ctrl: RTL and testbench

COUNT_SEQUENCER_CTRL -- requirements
Module: count_sequencer_ctrl

---
 rtl/count_sequencer_ctrl_if.sv | 25 ++
 rtl/count_sequencer_ctrl.sv | 85 ++++++++
 tb/tb_count_sequencer_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_ctrl_if.sv
// Control/status bundle between a job requester and count_sequencer_ctrl.
// The requester drives start/abort/hold/limit/reps; the sequencer drives status and count.
interface count_sequencer_ctrl_if;
    logic       start;
    logic       abort;
    logic       hold;
    logic [3:0] limit;
    logic [2:0] reps;
    logic       busy;
    logic       cnt_en;
    logic [3:0] q;
    logic [2:0] pass;
    logic       wrap;
    logic       done;

    modport master (
        output start, abort, hold, limit, reps,
        input  busy, cnt_en, q, pass, wrap, done
    );

    modport slave (
        input  start, abort, hold, limit, reps,
        output busy, cnt_en, q, pass, wrap, done
    );
endinterface

// File: rtl/count_sequencer_ctrl.sv
// Multi-pass count sequencer: counts 0..limit for reps+1 passes, with hold, abort and
// a one-cycle CLEAR before counting and a one-cycle DONE strobe afterwards.
module count_sequencer_ctrl (
    input logic                  clock,
    input logic                  reset,
    count_sequencer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] q_r;
    logic [3:0] limit_r;
    logic [2:0] pass_r;
    logic [2:0] reps_r;
    logic       at_limit;
    logic       last_pass;

    assign at_limit  = (q_r == limit_r);
    assign last_pass = (pass_r == reps_r);

    // NOTE: every register in this block uses non-blocking assignment so all
    // updates see the pre-edge values of state, q and pass.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            q_r     <= 4'd0;
            pass_r  <= 3'd0;
            limit_r <= 4'd0;
            reps_r  <= 3'd0;
        end else if (bus.abort && state != IDLE) begin
            state  <= IDLE;
            q_r    <= 4'd0;
            pass_r <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    // q and pass keep the finished job's values until a new start.
                    if (bus.start) begin
                        limit_r <= bus.limit;
                        reps_r  <= bus.reps;
                        pass_r  <= 3'd0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    q_r   <= 4'd0;
                    state <= RUN;
                end
                RUN: begin
                    if (!bus.hold) begin
                        if (!at_limit) begin
                            q_r <= q_r + 4'd1;
                        end else if (!last_pass) begin
                            q_r    <= 4'd0;
                            pass_r <= pass_r + 3'd1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decodes straight off the state register; only cnt_en and wrap also see hold/abort.
    assign bus.busy   = (state != IDLE);
    assign bus.cnt_en = (state == RUN) && !bus.hold;
    assign bus.wrap   = (state == RUN) && !bus.hold && !bus.abort && at_limit && !last_pass;
    assign bus.done   = (state == DONE);
    assign bus.q      = q_r;
    assign bus.pass   = pass_r;

endmodule

// File: tb/tb_count_sequencer_ctrl.sv
// Directed bench for count_sequencer_ctrl: inputs change and outputs are checked on the
// falling clock edge, with expected values derived from limit/reps/hold of each job.
module tb_count_sequencer_ctrl;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    count_sequencer_ctrl_if bus ();

    count_sequencer_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Issues a start, checks the CLEAR cycle, scrambles limit/reps and pulses start while
    // busy; returns on the falling edge of the first RUN cycle.
    task automatic start_job(input logic [3:0] lim, input logic [2:0] rp);
        bus.start = 1'b1;
        bus.limit = lim;
        bus.reps  = rp;
        @(negedge clock);
        bus.start = 1'b0;
        bus.limit = ~lim;
        bus.reps  = ~rp;
        #1;
        check("clear_busy", bus.busy, 1);
        check("clear_cnt_en", bus.cnt_en, 0);
        check("clear_done", bus.done, 0);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Runs one complete job; hold is raised for hold_n cycles when q first reaches hold_q.
    task automatic run_job(input logic [3:0] lim, input logic [2:0] rp,
                           input int hold_q, input int hold_n);
        int wraps;
        wraps = 0;
        start_job(lim, rp);
        for (int p = 0; p <= int'(rp); p++) begin
            for (int v = 0; v <= int'(lim); v++) begin
                if (p == 0 && v == hold_q) begin
                    for (int h = 0; h < hold_n; h++) begin
                        bus.hold = 1'b1;
                        #1;
                        check("hold_q", bus.q, v);
                        check("hold_cnt_en", bus.cnt_en, 0);
                        check("hold_wrap", bus.wrap, 0);
                        check("hold_done", bus.done, 0);
                        @(negedge clock);
                    end
                    bus.hold = 1'b0;
                end
                #1;
                check("run_q", bus.q, v);
                check("run_pass", bus.pass, p);
                check("run_cnt_en", bus.cnt_en, 1);
                check("run_busy", bus.busy, 1);
                check("run_done", bus.done, 0);
                check("run_wrap", bus.wrap, (v == int'(lim) && p != int'(rp)) ? 1 : 0);
                if (bus.wrap) wraps++;
                @(negedge clock);
            end
        end
        #1;
        check("done_strobe", bus.done, 1);
        check("done_wrap", bus.wrap, 0);
        check("done_busy", bus.busy, 1);
        check("done_q", bus.q, lim);
        check("done_pass", bus.pass, rp);
        @(negedge clock);
        #1;
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_cnt_en", bus.cnt_en, 0);
        check("idle_q", bus.q, lim);
        check("idle_pass", bus.pass, rp);
        check("wrap_count", wraps, rp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.hold  = 1'b0;
        bus.limit = 4'd0;
        bus.reps  = 3'd0;
        repeat (2) @(negedge clock);
        bus.start = 1'b1;
        bus.hold  = 1'b1;
        bus.abort = 1'b1;
        @(negedge clock);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_cnt_en", bus.cnt_en, 0);
        check("rst_q", bus.q, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_wrap", bus.wrap, 0);
        check("rst_done", bus.done, 0);
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        @(negedge clock);

        // Single pass, multi-pass, hold, degenerate and maximal jobs.
        run_job(4'd3, 3'd0, -1, 0);
        run_job(4'd2, 3'd2, -1, 0);
        run_job(4'd7, 3'd0, 2, 4);
        run_job(4'd0, 3'd1, -1, 0);
        run_job(4'd15, 3'd7, -1, 0);
        run_job(4'd4, 3'd1, 4, 2);

        // Abort at q=4 of a limit=9 job.
        start_job(4'd9, 3'd1);
        for (int v = 0; v < 4; v++) begin
            #1;
            check("abort_pre_q", bus.q, v);
            @(negedge clock);
        end
        bus.abort = 1'b1;
        #1;
        check("abort_cycle_q", bus.q, 4);
        check("abort_cycle_wrap", bus.wrap, 0);
        @(negedge clock);
        bus.abort = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_q", bus.q, 0);
        check("abort_pass", bus.pass, 0);
        check("abort_done", bus.done, 0);
        @(negedge clock);
        #1;
        check("abort_no_done", bus.done, 0);
        check("abort_still_idle", bus.busy, 0);

        // Abort coinciding with DONE still shows done, then clears q and pass.
        start_job(4'd1, 3'd0);
        repeat (2) @(negedge clock);
        bus.abort = 1'b1;
        #1;
        check("abort_done_strobe", bus.done, 1);
        @(negedge clock);
        bus.abort = 1'b0;
        #1;
        check("abort_done_busy", bus.busy, 0);
        check("abort_done_q", bus.q, 0);
        check("abort_done_pass", bus.pass, 0);
        check("abort_done_done", bus.done, 0);

        // Reset in the middle of a limit=5 job at q=3, then a clean job.
        start_job(4'd5, 3'd0);
        repeat (3) @(negedge clock);
        #1;
        check("prereset_q", bus.q, 3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_q", bus.q, 0);
        check("midrst_pass", bus.pass, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_cnt_en", bus.cnt_en, 0);
        check("midrst_done", bus.done, 0);
        @(negedge clock);
        run_job(4'd3, 3'd0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
